// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-skip adder.
// Default widths, stage-count helper and the stage payload record.
package csa_pkg;

  localparam int CSA_WIDTH          = 16;
  localparam int CSA_BLK            = 4;
  localparam int CSA_BLKS_PER_STAGE = 2;

  // Pipeline depth: one register bank per group of skip blocks.
  function automatic int csa_num_stages(input int width, input int blk, input int bps);
    int nblk;
    nblk = width / blk;
    return (nblk + bps - 1) / bps;
  endfunction

  // Stage payload at the default width (valid, partial sum, boundary carry).
  typedef struct packed {
    logic                 vld;
    logic [CSA_WIDTH-1:0] sum;
    logic                 cry;
  } csa_stage_t;

endpackage

// File: rtl/carry_skip_blk.sv
// Combinational BLK-bit ripple block with carry-skip mux.
// When every bit propagates, the block's carry-in bypasses the ripple.
module carry_skip_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           pall
);

  logic           rc;

  assign pall      = &(a ^ b);
  assign {rc, s}   = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, cin};
  assign cout      = pall ? cin : rc;

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder: Y = A + B + carryin, register bank after
// every BLKS_PER_STAGE skip blocks, valid/ready on both sides.
// Optional macro CSA_OVF_FLAG_EN adds a registered signed-overflow output.
module pipelined_carry_skip_adder
  import csa_pkg::*;
#(
  parameter int WIDTH          = CSA_WIDTH,
  parameter int BLK            = CSA_BLK,
  parameter int BLKS_PER_STAGE = CSA_BLKS_PER_STAGE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             carryout
`ifdef CSA_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NUM_BLK = WIDTH / BLK;
  localparam int STAGES  = csa_num_stages(WIDTH, BLK, BLKS_PER_STAGE);

  if ((WIDTH % BLK) != 0 || BLKS_PER_STAGE < 1) begin : g_bad_cfg
    $error("pipelined_carry_skip_adder: WIDTH must be a multiple of BLK and BLKS_PER_STAGE >= 1");
  end

  // index k = stage k: s* is the stage's source, n* its result, r* its register bank
  logic [STAGES:1]            vld_pipe, ld, sv;
  logic [STAGES:1][WIDTH-1:0] ra, rb, rs, sa, sb, ss, ns, msk, keep;
  logic [STAGES:1]            rc, sc, nc;
  logic [WIDTH-1:0]           bs;
  logic [NUM_BLK-1:0]         bpall;

  // skip blocks; block j belongs to stage j/BLKS_PER_STAGE+1
  for (genvar j = 0; j < NUM_BLK; j++) begin : g_blk
    localparam int K = j / BLKS_PER_STAGE + 1;
    logic ci, co, pl;
    if (j % BLKS_PER_STAGE == 0) begin : g_first
      assign ci = sc[K];
    end else begin : g_chain
      assign ci = g_blk[j-1].co;
    end
    carry_skip_blk #(.BLK(BLK)) u_blk (
      .a    (sa[K][j*BLK +: BLK]),
      .b    (sb[K][j*BLK +: BLK]),
      .cin  (ci),
      .s    (bs[j*BLK +: BLK]),
      .cout (co),
      .pall (pl)
    );
    assign bpall[j] = pl;
  end

  // per-stage source selection, result merge and load enable
  for (genvar k = 1; k <= STAGES; k++) begin : g_stg
    localparam int FB = (k - 1) * BLKS_PER_STAGE;
    localparam int LB = ((k * BLKS_PER_STAGE < NUM_BLK) ? k * BLKS_PER_STAGE : NUM_BLK) - 1;
    assign msk[k]  = ({WIDTH{1'b1}} << (FB * BLK)) & ~({WIDTH{1'b1}} << ((LB + 1) * BLK));
    assign keep[k] = {WIDTH{1'b1}} << ((LB + 1) * BLK);
    if (k == 1) begin : g_src_in
      assign sa[k] = A;
      assign sb[k] = B;
      assign ss[k] = '0;
      assign sc[k] = carryin;
      assign sv[k] = in_valid;
    end else begin : g_src_reg
      assign sa[k] = ra[k-1];
      assign sb[k] = rb[k-1];
      assign ss[k] = rs[k-1];
      assign sc[k] = rc[k-1];
      assign sv[k] = vld_pipe[k-1];
    end
    assign ns[k] = (ss[k] & ~msk[k]) | (bs & msk[k]);
    // stage-level skip: whole stage propagating passes its carry-in straight out
    assign nc[k] = (&bpall[LB:FB]) ? sc[k] : g_blk[LB].co;
    // a bank can load unless it and every bank after it is full and the output is stalled
    assign ld[k] = out_ready | ~(&vld_pipe[STAGES:k]);
  end

  // register banks; payload only updates on a valid load so Y holds between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ra       <= '0;
      rb       <= '0;
      rs       <= '0;
      rc       <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (ld[k]) begin
          vld_pipe[k] <= sv[k];
          if (sv[k]) begin
            ra[k] <= sa[k] & keep[k];
            rb[k] <= sb[k] & keep[k];
            rs[k] <= ns[k];
            rc[k] <= nc[k];
          end
        end
      end
    end
  end

  assign in_ready  = ld[1];
  assign out_valid = vld_pipe[STAGES];
  assign Y         = rs[STAGES];
  assign carryout  = rc[STAGES];

  // the last bank never carries operand bits onward; synthesis trims it
  logic unused_bits;
  assign unused_bits = ^{ra[STAGES], rb[STAGES]};

`ifdef CSA_OVF_FLAG_EN
  logic ovf_nxt;
  assign ovf_nxt = sa[STAGES][WIDTH-1] ^ sb[STAGES][WIDTH-1] ^ ns[STAGES][WIDTH-1] ^ nc[STAGES];

  // overflow flag registered with the last bank, same stall behaviour as Y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ovf <= 1'b0;
    else if (ld[STAGES] && sv[STAGES]) ovf <= ovf_nxt;
  end
`endif

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Self-checking bench for pipelined_carry_skip_adder (WIDTH=16, BLK=4, 2 stages).
// Scoreboard monitor compares every emitted result against A+B+cin in order.
module tb_pipelined_carry_skip_adder;

  localparam int W     = 16;
  localparam int NRAND = 10000;

  logic         clk, rst_n, in_valid, in_ready, carryin, out_valid, out_ready, carryout;
  logic [W-1:0] A, B, Y;
`ifdef CSA_OVF_FLAG_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] y;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_in   = 0;
  int   n_out  = 0;

  pipelined_carry_skip_adder #(.WIDTH(W), .BLK(4), .BLKS_PER_STAGE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .carryin   (carryin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .carryout  (carryout)
`ifdef CSA_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: sample handshakes on the falling edge, pop before push
  always @(negedge clk) begin
    exp_t e, x;
    logic [W:0] s;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output got Y=%h co=%b with nothing expected", Y, carryout);
        end else begin
          e = sb.pop_front();
          if (Y !== e.y || carryout !== e.co) begin
            errors++;
            $display("FAIL sb_result got Y=%h co=%b expected Y=%h co=%b", Y, carryout, e.y, e.co);
          end
`ifdef CSA_OVF_FLAG_EN
          if (ovf !== e.ov) begin
            errors++;
            $display("FAIL sb_ovf got %b expected %b (Y=%h)", ovf, e.ov, e.y);
          end
`endif
        end
      end
      if (in_valid && in_ready) begin
        n_in++;
        s    = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, carryin};
        x.y  = s[W-1:0];
        x.co = s[W];
        x.ov = (A[W-1] == B[W-1]) && (s[W-1] != A[W-1]);
        sb.push_back(x);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold an operand until accepted; returns 1ns after the accepting edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bit acc;
    int n;
    A = a; B = b; carryin = c; in_valid = 1'b1;
    acc = 0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout a=%h b=%h never accepted", a, b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; carryin = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || Y !== '0 || carryout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ov=%b Y=%h co=%b expected 0/0000/0", out_valid, Y, carryout);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    tick();
    out_ready = 1'b1;
    A = 16'h00FF; B = 16'h0001; carryin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early out_valid=%b one cycle after accept, expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || Y !== 16'h0100 || carryout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got ov=%b Y=%h co=%b expected 1/0100/0", out_valid, Y, carryout);
    end
    tick();
  endtask

  task automatic test_skip();
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || Y !== 16'h0000 || carryout !== 1'b1) begin
      errors++;
      $display("FAIL skip_full_carry got ov=%b Y=%h co=%b expected 1/0000/1", out_valid, Y, carryout);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || Y !== 16'hFFFF || carryout !== 1'b0) begin
      errors++;
      $display("FAIL skip_no_carry got ov=%b Y=%h co=%b expected 1/FFFF/0", out_valid, Y, carryout);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || Y !== 16'hFFFF || carryout !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got ov=%b Y=%h co=%b expected 0/FFFF/0", out_valid, Y, carryout);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0);
    send(16'hA000, 16'h6001, 1'b1);
    A = 16'h0F0F; B = 16'h00F1; carryin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || Y !== 16'h2345 || carryout !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got ir=%b ov=%b Y=%h expected 0/1/2345", i, in_ready, out_valid, Y);
      end
      tick();
    end
    out_ready = 1'b1;
    send(16'h0F0F, 16'h00F1, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stall_drain %0d results still pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_inflight();
    int out0;
    out_ready = 1'b1;
    send(16'h0101, 16'h0202, 1'b0);
    send(16'h0303, 16'h0404, 1'b1);
    out0 = n_out;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Y !== '0 || carryout !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight got ov=%b Y=%h co=%b expected 0/0000/0", out_valid, Y, carryout);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_in_ready got %b expected 1", in_ready);
    end
    repeat (4) tick();
    checks++;
    if (n_out != out0) begin
      errors++;
      $display("FAIL rst_discard emitted %0d ops after reset, expected 0", n_out - out0);
    end
  endtask

`ifdef CSA_OVF_FLAG_EN
  task automatic test_ovf();
    out_ready = 1'b1;
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    checks++;
    if (Y !== 16'h8000 || ovf !== 1'b1 || carryout !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pos got Y=%h ovf=%b co=%b expected 8000/1/0", Y, ovf, carryout);
    end
    send(16'h0001, 16'h0001, 1'b0);
    checks++;
    if (Y !== 16'h0000 || ovf !== 1'b1 || carryout !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg got Y=%h ovf=%b co=%b expected 0000/1/1", Y, ovf, carryout);
    end
    tick();
    checks++;
    if (Y !== 16'h0002 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_none got Y=%h ovf=%b expected 0002/0", Y, ovf);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    int in0, out0, sent, cyc;
    bit acc;
    in0 = n_in; out0 = n_out; sent = 0; cyc = 0;
    in_valid = 1'b0;
    while ((sent < NRAND || sb.size() != 0) && cyc < 60000) begin
      if (!in_valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
        A = W'($urandom); B = W'($urandom); carryin = 1'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if ((n_in - in0) != NRAND || (n_out - out0) != NRAND || sb.size() != 0) begin
      errors++;
      $display("FAIL random_counts in=%0d out=%0d pending=%0d expected %0d/%0d/0",
               n_in - in0, n_out - out0, sb.size(), NRAND, NRAND);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_back_to_back();
    test_reset_inflight();
`ifdef CSA_OVF_FLAG_EN
    test_ovf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
